// File: rtl/gear_pkg.sv
// Shared types and defaults for the gear shift controller: lever mode
// encoding, FSM state type, threshold/hysteresis/dwell defaults and a
// saturating subtract helper used for the downshift thresholds.
package gear_pkg;

  typedef enum logic [1:0] {
    MODE_P = 2'b00,
    MODE_N = 2'b01,
    MODE_R = 2'b10,
    MODE_D = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_PARK,
    ST_NEUTRAL,
    ST_REVERSE,
    ST_DRIVE,
    ST_SHIFTING
  } state_e;

  localparam int unsigned DEF_UP_THR1   = 20;
  localparam int unsigned DEF_UP_THR2   = 40;
  localparam int unsigned DEF_UP_THR3   = 60;
  localparam int unsigned DEF_HYST      = 5;
  localparam int unsigned DEF_SHIFT_DLY = 8;

  // a - b, clamped at zero so a small threshold never wraps to a huge one
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  // Lever mode that a settled state corresponds to; SHIFTING only occurs in D
  function automatic mode_e state_mode(input state_e s);
    case (s)
      ST_PARK:    return MODE_P;
      ST_NEUTRAL: return MODE_N;
      ST_REVERSE: return MODE_R;
      default:    return MODE_D;
    endcase
  endfunction

  function automatic state_e mode_state(input mode_e m);
    case (m)
      MODE_P:  return ST_PARK;
      MODE_N:  return ST_NEUTRAL;
      MODE_R:  return ST_REVERSE;
      default: return ST_DRIVE;
    endcase
  endfunction

endpackage

// File: rtl/shift_timer.sv
// Dwell countdown for the gear shift controller. A load starts the count
// at load_val; it then decrements to zero. done marks the last dwell cycle
// (count == 1), so a load of N keeps the owner busy for exactly N cycles.
module shift_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count = r_count;
  assign done  = (r_count == WIDTH'(1));

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear selector / automatic shift controller. Arbitrates driver lever
// requests (P > N > R > D) against brake and speed interlocks, and in D
// steps the gear up/down one at a time with hysteresis, followed by a
// SHIFTING dwell timed by shift_timer.
// Optional feature: define GEAR_SHIFT_KICKDOWN_EN to enable a one-gear
// downshift on a kickdown rising edge while in DRIVE.
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int unsigned UP_THR1   = DEF_UP_THR1,
  parameter int unsigned UP_THR2   = DEF_UP_THR2,
  parameter int unsigned UP_THR3   = DEF_UP_THR3,
  parameter int unsigned HYST      = DEF_HYST,
  parameter int unsigned SHIFT_DLY = DEF_SHIFT_DLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_p,
  input  logic       sel_n,
  input  logic       sel_r,
  input  logic       sel_d,
  input  logic       brake,
  input  logic [7:0] speed,
  input  logic       kickdown,
  output logic [1:0] mode,
  output logic [1:0] gear,
  output logic       req_p,
  output logic       req_n,
  output logic       req_r,
  output logic       req_d,
  output logic       shift_busy,
  output logic       interlock
);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_gear, w_gear_nxt;
  logic [3:0]  r_req, w_req_nxt;       // indexed by mode_e
  logic        r_interlock, w_blocked;
  logic        w_load;
  logic        w_timer_done;
  logic [7:0]  w_dwell_cnt_unused;

  mode_e       w_cur_mode;
  mode_e       w_lev_mode;
  logic        w_lev_valid, w_lev_ok, w_accept;
  logic        w_up, w_dn, w_kick_dn;

  // Upshift threshold into gear g (g = 1..3); zero for gear 0
  function automatic logic [7:0] up_thr(input logic [1:0] g);
    case (g)
      2'd1:    return 8'(UP_THR1);
      2'd2:    return 8'(UP_THR2);
      2'd3:    return 8'(UP_THR3);
      default: return 8'd0;
    endcase
  endfunction

  assign w_cur_mode = state_mode(r_state);

  // Lever arbitration: fixed priority first, then the same-mode filter
  always_comb begin
    w_lev_valid = 1'b1;
    w_lev_mode  = MODE_D;
    if      (sel_p) w_lev_mode = MODE_P;
    else if (sel_n) w_lev_mode = MODE_N;
    else if (sel_r) w_lev_mode = MODE_R;
    else if (sel_d) w_lev_mode = MODE_D;
    else            w_lev_valid = 1'b0;
  end

  assign w_lev_ok = !(r_state == ST_PARK && !brake)
                 && !((w_lev_mode == MODE_P || w_lev_mode == MODE_R) && speed != 8'd0)
                 && !(r_state == ST_REVERSE && w_lev_mode == MODE_D && speed != 8'd0);

  assign w_accept = w_lev_valid && (w_lev_mode != w_cur_mode) && w_lev_ok;

  assign w_up = (r_gear != 2'd3) && (speed >= up_thr(r_gear + 2'd1));
  assign w_dn = (r_gear != 2'd0) && (speed <  sat_sub(up_thr(r_gear), 8'(HYST)));

`ifdef GEAR_SHIFT_KICKDOWN_EN
  logic r_kick_prev;

  // Previous kickdown level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) r_kick_prev <= 1'b0;
    else       r_kick_prev <= kickdown;
  end

  assign w_kick_dn = kickdown && !r_kick_prev && (r_gear != 2'd0);
`else
  logic w_kick_unused;
  assign w_kick_unused = kickdown;
  assign w_kick_dn     = 1'b0;
`endif

  // State register plus the registered outputs (gear, command pulses, interlock)
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled synchronously on the clock edge, so it only takes
    // effect at an edge and never creates an asynchronous path.
    if (reset) begin
      r_state     <= ST_PARK;
      r_gear      <= 2'd0;
      r_req       <= 4'b0000;
      r_interlock <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gear      <= w_gear_nxt;
      r_req       <= w_req_nxt;
      r_interlock <= w_blocked;
    end
  end

  // Next-state logic: lever changes win over gear shifts; SHIFTING ignores both
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    w_state_nxt = r_state;
    w_gear_nxt  = r_gear;
    w_req_nxt   = 4'b0000;
    w_blocked   = 1'b0;
    w_load      = 1'b0;
    if (r_state == ST_SHIFTING) begin
      if (w_timer_done) w_state_nxt = ST_DRIVE;
    end else if (w_accept) begin
      w_state_nxt           = mode_state(w_lev_mode);
      w_gear_nxt            = 2'd0;
      w_req_nxt[w_lev_mode] = 1'b1;
    end else begin
      w_blocked = w_lev_valid && (w_lev_mode != w_cur_mode);
      if (r_state == ST_DRIVE) begin
        if (w_kick_dn || w_dn) begin
          w_gear_nxt  = r_gear - 2'd1;
          w_state_nxt = ST_SHIFTING;
          w_load      = 1'b1;
        end else if (w_up) begin
          w_gear_nxt  = r_gear + 2'd1;
          w_state_nxt = ST_SHIFTING;
          w_load      = 1'b1;
        end
      end
    end
  end

  // Outputs decoded from the current state and registers
  always_comb begin
    mode       = w_cur_mode;
    shift_busy = (r_state == ST_SHIFTING);
    gear       = r_gear;
    req_p      = r_req[MODE_P];
    req_n      = r_req[MODE_N];
    req_r      = r_req[MODE_R];
    req_d      = r_req[MODE_D];
    interlock  = r_interlock;
  end

  shift_timer #(
    .WIDTH (8)
  ) u_shift_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (8'(SHIFT_DLY)),
    .count    (w_dwell_cnt_unused),
    .done     (w_timer_done)
  );

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed self-checking bench for gear_shift_ctrl with default parameters.
// Kickdown expectations follow GEAR_SHIFT_KICKDOWN_EN.
module tb_gear_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel_p = 1'b0, sel_n = 1'b0, sel_r = 1'b0, sel_d = 1'b0;
  logic       brake = 1'b0;
  logic [7:0] speed = 8'd0;
  logic       kickdown = 1'b0;
  logic [1:0] mode, gear;
  logic       req_p, req_n, req_r, req_d, shift_busy, interlock;

  int errors = 0;
  int checks = 0;

  gear_shift_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sel_p      (sel_p),
    .sel_n      (sel_n),
    .sel_r      (sel_r),
    .sel_d      (sel_d),
    .brake      (brake),
    .speed      (speed),
    .kickdown   (kickdown),
    .mode       (mode),
    .gear       (gear),
    .req_p      (req_p),
    .req_n      (req_n),
    .req_r      (req_r),
    .req_d      (req_d),
    .shift_busy (shift_busy),
    .interlock  (interlock)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the dwell to finish
  task automatic wait_dwell(input string name);
    for (int i = 0; i < 300 && shift_busy; i++) tick();
    checks++;
    if (shift_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_dwell_end: shift_busy=%0b expected 0", name, shift_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({mode, gear} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mode_gear: mode=%0d gear=%0d expected 0 0", mode, gear);
    end
    checks++;
    if ({req_p, req_n, req_r, req_d, shift_busy, interlock} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: req=%b%b%b%b busy=%0b ilk=%0b expected all 0",
               req_p, req_n, req_r, req_d, shift_busy, interlock);
    end
    reset = 1'b0;
  endtask

  task automatic test_park_interlock();
    sel_d = 1'b1; brake = 1'b0; speed = 8'd0;
    tick();
    checks++;
    if (interlock !== 1'b1 || mode !== 2'b00) begin
      errors++;
      $display("FAIL park_no_brake: ilk=%0b mode=%0d expected 1 0", interlock, mode);
    end
    brake = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b11 || req_d !== 1'b1 || gear !== 2'd0 || interlock !== 1'b0) begin
      errors++;
      $display("FAIL park_to_d: mode=%0d req_d=%0b gear=%0d ilk=%0b expected 3 1 0 0",
               mode, req_d, gear, interlock);
    end
    sel_d = 1'b0; brake = 1'b0;
    tick();
    checks++;
    if (req_d !== 1'b0 || mode !== 2'b11) begin
      errors++;
      $display("FAIL req_d_pulse: req_d=%0b mode=%0d expected 0 3", req_d, mode);
    end
  endtask

  task automatic test_upshift();
    int n;
    speed = 8'd25;
    tick();
    checks++;
    if (gear !== 2'd1 || shift_busy !== 1'b1) begin
      errors++;
      $display("FAIL up_g1: gear=%0d busy=%0b expected 1 1", gear, shift_busy);
    end
    speed = 8'd45;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!shift_busy) break;
      n++;
      checks++;
      if (gear !== 2'd1) begin
        errors++;
        $display("FAIL up_hold_in_dwell: gear=%0d expected 1", gear);
      end
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL dwell_len: busy cycles=%0d expected 8", n);
    end
    checks++;
    if (gear !== 2'd1) begin
      errors++;
      $display("FAIL up_dwell_end_gear: gear=%0d expected 1", gear);
    end
    tick();
    checks++;
    if (gear !== 2'd2 || shift_busy !== 1'b1) begin
      errors++;
      $display("FAIL up_g2: gear=%0d busy=%0b expected 2 1", gear, shift_busy);
    end
    wait_dwell("up_g2");
  endtask

  task automatic test_downshift();
    speed = 8'd36;
    tick();
    tick();
    checks++;
    if (gear !== 2'd2 || shift_busy !== 1'b0) begin
      errors++;
      $display("FAIL down_hold_36: gear=%0d busy=%0b expected 2 0", gear, shift_busy);
    end
    speed = 8'd34;
    tick();
    checks++;
    if (gear !== 2'd1 || shift_busy !== 1'b1) begin
      errors++;
      $display("FAIL down_34: gear=%0d busy=%0b expected 1 1", gear, shift_busy);
    end
    speed = 8'd30;
    wait_dwell("down");
    tick();
    checks++;
    if (gear !== 2'd1) begin
      errors++;
      $display("FAIL down_settle: gear=%0d expected 1", gear);
    end
  endtask

  task automatic test_reverse_interlock();
    sel_r = 1'b1;
    tick();
    checks++;
    if (interlock !== 1'b1 || mode !== 2'b11 || gear !== 2'd1) begin
      errors++;
      $display("FAIL rev_moving: ilk=%0b mode=%0d gear=%0d expected 1 3 1", interlock, mode, gear);
    end
    speed = 8'd0;
    tick();
    checks++;
    if (mode !== 2'b10 || req_r !== 1'b1 || gear !== 2'd0 || interlock !== 1'b0 || shift_busy !== 1'b0) begin
      errors++;
      $display("FAIL rev_stopped: mode=%0d req_r=%0b gear=%0d ilk=%0b busy=%0b expected 2 1 0 0 0",
               mode, req_r, gear, interlock, shift_busy);
    end
    sel_r = 1'b0;
    tick();
    checks++;
    if (req_r !== 1'b0 || mode !== 2'b10) begin
      errors++;
      $display("FAIL req_r_pulse: req_r=%0b mode=%0d expected 0 2", req_r, mode);
    end
  endtask

  task automatic test_reset_mid_shift();
    sel_d = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b11 || req_d !== 1'b1) begin
      errors++;
      $display("FAIL r_to_d: mode=%0d req_d=%0b expected 3 1", mode, req_d);
    end
    sel_d = 1'b0;
    speed = 8'd25;
    tick();
    tick();
    tick();
    checks++;
    if (shift_busy !== 1'b1 || gear !== 2'd1) begin
      errors++;
      $display("FAIL mid_shift_setup: busy=%0b gear=%0d expected 1 1", shift_busy, gear);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b00 || gear !== 2'd0 || shift_busy !== 1'b0 || interlock !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: mode=%0d gear=%0d busy=%0b ilk=%0b expected 0 0 0 0",
               mode, gear, shift_busy, interlock);
    end
    reset = 1'b0;
    speed = 8'd0;
    tick();
  endtask

  task automatic test_kickdown();
    sel_d = 1'b1; brake = 1'b1;
    tick();
    sel_d = 1'b0; brake = 1'b0;
    speed = 8'd70;
    tick();
    wait_dwell("kd_g1");
    tick();
    wait_dwell("kd_g2");
    tick();
    wait_dwell("kd_g3");
    checks++;
    if (gear !== 2'd3 || mode !== 2'b11) begin
      errors++;
      $display("FAIL kd_setup: gear=%0d mode=%0d expected 3 3", gear, mode);
    end
    kickdown = 1'b1;
    tick();
`ifdef GEAR_SHIFT_KICKDOWN_EN
    checks++;
    if (gear !== 2'd2 || shift_busy !== 1'b1) begin
      errors++;
      $display("FAIL kickdown_on: gear=%0d busy=%0b expected 2 1", gear, shift_busy);
    end
`else
    checks++;
    if (gear !== 2'd3 || shift_busy !== 1'b0) begin
      errors++;
      $display("FAIL kickdown_off: gear=%0d busy=%0b expected 3 0", gear, shift_busy);
    end
`endif
    kickdown = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_park_interlock();
    test_upshift();
    test_downshift();
    test_reverse_interlock();
    test_reset_mid_shift();
    test_kickdown();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
